// File: rtl/scandoubler_ctrl.sv
// Scandoubler timing supervisor: measures line/frame timing, locks, generates doubler enables.
// Optional interlace field detection is built when SCANDOUBLER_CTRL_INTERLACE_EN is defined.
`timescale 1ns/1ps

module scandoubler_ctrl #(
    parameter int HS_TOL     = 4,
    parameter int LOCK_LINES = 16,
    parameter int BYPASS_MAX = 1200
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic [1:0]  scanlines_req,
    output logic        ce_x1,
    output logic        ce_x2,
    output logic        locked,
    output logic        bypass,
    output logic [11:0] hs_period,
    output logic [9:0]  vs_lines,
    output logic [1:0]  scanlines_out,
    output logic        field
);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t      state;
    logic        hs_q;
    logic        vs_q;
    logic        hfe;
    logic        vfe;
    logic [11:0] pcnt;
    logic [9:0]  lcnt;
    logic [11:0] ref_period;
    logic [7:0]  match_cnt;
    logic [1:0]  div;

    logic [12:0] period_now;
    logic [12:0] period_diff;
    logic        period_match;
    logic        lock_reached;
    logic        timeout;

    assign hfe = hs_q & ~hs_in;
    assign vfe = vs_q & ~vs_in;

    // Line length ending at this HFE, kept 13 bits wide so the tolerance and
    // bypass compares see a saturated (4096) period as long rather than zero.
    assign period_now   = {1'b0, pcnt} + 13'd1;
    assign period_diff  = (period_now >= {1'b0, ref_period}) ? (period_now - {1'b0, ref_period})
                                                             : ({1'b0, ref_period} - period_now);
    assign period_match = (period_diff <= 13'(HS_TOL));
    assign lock_reached = ((match_cnt + 8'd1) == 8'(LOCK_LINES));
    assign timeout      = (pcnt == 12'hFFF);

    // Enables decode straight from registered div/state, so they carry no input-side glitches.
    assign ce_x1 = (state != ST_SEARCH) && (div == 2'd1);
    assign ce_x2 = (state != ST_SEARCH) && div[0];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            pcnt          <= '0;
            lcnt          <= '0;
            div           <= '0;
            hs_period     <= '0;
            vs_lines      <= '0;
            scanlines_out <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            hs_q <= hs_in;
            vs_q <= vs_in;

            if (hfe) begin
                pcnt      <= '0;
                hs_period <= period_now[11:0];
            end else if (!timeout) begin
                pcnt <= pcnt + 12'd1;
            end

            // A vsync landing on the same cycle as hsync starts the new frame
            // with that line already counted.
            if (vfe) begin
                vs_lines <= lcnt;
                lcnt     <= hfe ? 10'd1 : 10'd0;
            end else if (hfe && (lcnt != 10'h3FF)) begin
                lcnt <= lcnt + 10'd1;
            end

            div           <= hfe ? 2'd0 : div + 2'd1;
            scanlines_out <= (locked && !bypass) ? scanlines_req : 2'd0;
        end
    end

`ifdef SCANDOUBLER_CTRL_INTERLACE_EN
    logic [11:0] half_p;
    logic [11:0] eighth_p;
    logic [11:0] field_lo;
    logic [11:0] field_hi;
    logic        field_mid;

    assign half_p    = hs_period >> 1;
    assign eighth_p  = hs_period >> 3;
    assign field_lo  = half_p - eighth_p;
    assign field_hi  = half_p + eighth_p;
    assign field_mid = (pcnt > field_lo) && (pcnt < field_hi);
`else
    assign field = 1'b0;
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_SEARCH;
            ref_period <= '0;
            match_cnt  <= '0;
            locked     <= 1'b0;
            bypass     <= 1'b0;
`ifdef SCANDOUBLER_CTRL_INTERLACE_EN
            field      <= 1'b0;
`endif
        end else begin
`ifdef SCANDOUBLER_CTRL_INTERLACE_EN
            if (state == ST_SEARCH) begin
                field <= 1'b0;
            end else if (vfe) begin
                field <= field_mid;
            end
`endif
            case (state)
                ST_SEARCH: begin
                    locked <= 1'b0;
                    bypass <= 1'b0;
                    if (hfe) begin
                        state     <= ST_MEASURE;
                        match_cnt <= '0;
                    end
                end

                ST_MEASURE: begin
                    if (hfe) begin
                        if (period_match) begin
                            match_cnt <= match_cnt + 8'd1;
                            if (lock_reached) begin
                                state  <= ST_LOCKED;
                                locked <= 1'b1;
                                bypass <= (period_now <= 13'(BYPASS_MAX));
                            end
                        end else begin
                            ref_period <= period_now[11:0];
                            match_cnt  <= '0;
                        end
                    end else if (timeout) begin
                        state  <= ST_SEARCH;
                        locked <= 1'b0;
                        bypass <= 1'b0;
                    end
                end

                ST_LOCKED: begin
                    if (hfe) begin
                        if (!period_match) begin
                            state      <= ST_MEASURE;
                            ref_period <= period_now[11:0];
                            match_cnt  <= '0;
                            locked     <= 1'b0;
                            bypass     <= 1'b0;
                        end
                    end else if (timeout) begin
                        state  <= ST_SEARCH;
                        locked <= 1'b0;
                        bypass <= 1'b0;
                    end
                end

                default: begin
                    state  <= ST_SEARCH;
                    locked <= 1'b0;
                    bypass <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scandoubler_ctrl.sv
// Directed bench for scandoubler_ctrl: lock/unlock, bypass, timeout, enables, frame count, reset.
// Field expectations follow SCANDOUBLER_CTRL_INTERLACE_EN when it is defined.
`timescale 1ns/1ps

module tb_scandoubler_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        hs_in;
    logic        vs_in;
    logic [1:0]  scanlines_req;
    logic        ce_x1;
    logic        ce_x2;
    logic        locked;
    logic        bypass;
    logic [11:0] hs_period;
    logic [9:0]  vs_lines;
    logic [1:0]  scanlines_out;
    logic        field;

    int n_tests = 0;
    int n_fail  = 0;

    scandoubler_ctrl dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .hs_in         (hs_in),
        .vs_in         (vs_in),
        .scanlines_req (scanlines_req),
        .ce_x1         (ce_x1),
        .ce_x2         (ce_x2),
        .locked        (locked),
        .bypass        (bypass),
        .hs_period     (hs_period),
        .vs_lines      (vs_lines),
        .scanlines_out (scanlines_out),
        .field         (field)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // NOTE: inputs change and outputs are sampled 1 ns after the rising edge,
    // well clear of the edge the DUT acts on.
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // One line of 'period' cycles: hs low for the first 4 cycles, optional vs
    // pulse starting at cycle vs_at. Enables are checked on cycles 1..12.
    task automatic drive_line(input int period, input int vs_at, input bit chk_ce);
        for (int c = 0; c < period; c++) begin
            hs_in = (c < 4) ? 1'b0 : 1'b1;
            vs_in = (vs_at >= 0 && c >= vs_at && c < vs_at + 4) ? 1'b0 : 1'b1;
            if (chk_ce && c >= 1 && c <= 12) begin
                check("ce_x1_phase", 32'(ce_x1), 32'((c % 4) == 2));
                check("ce_x2_phase", 32'(ce_x2), 32'((c % 2) == 0));
            end
            tick();
        end
    endtask

    task automatic plain_lines(input int n, input int period);
        for (int i = 0; i < n; i++) drive_line(period, -1, 1'b0);
    endtask

    initial begin
        reset_n       = 1'b0;
        hs_in         = 1'b1;
        vs_in         = 1'b1;
        scanlines_req = 2'd2;
        #3;
        check("rst_locked",    32'(locked),        0);
        check("rst_bypass",    32'(bypass),        0);
        check("rst_hs_period", 32'(hs_period),     0);
        check("rst_vs_lines",  32'(vs_lines),      0);
        check("rst_scanlines", 32'(scanlines_out), 0);
        check("rst_ce_x1",     32'(ce_x1),         0);
        check("rst_ce_x2",     32'(ce_x2),         0);
        check("rst_field",     32'(field),         0);
        #4 reset_n = 1'b1;
        tick(); tick(); tick();

        // Lock on 1201-cycle lines: just above the bypass threshold.
        plain_lines(17, 1201);
        check("lock_not_yet", 32'(locked), 0);
        drive_line(1201, -1, 1'b0);
        check("lock_at_18",      32'(locked),        1);
        check("lock_bypass",     32'(bypass),        0);
        check("lock_hs_period",  32'(hs_period),     1201);
        check("lock_scanlines",  32'(scanlines_out), 2);
        drive_line(1201, -1, 1'b1);
        check("lock_hold", 32'(locked), 1);

        // Alternating lengths within tolerance keep lock.
        for (int i = 0; i < 4; i++) begin
            drive_line((i % 2 == 0) ? 1205 : 1201, -1, 1'b0);
            check("tol_hold", 32'(locked), 1);
        end

        // hsync stops: timeout once pcnt hits 4095.
        for (int c = 0; c < 4200; c++) begin
            hs_in = (c < 4) ? 1'b0 : 1'b1;
            if (c == 4096) check("tmo_before", 32'(locked), 1);
            if (c == 4097) check("tmo_unlock", 32'(locked), 0);
            if (c == 4098) begin
                check("tmo_ce_x1", 32'(ce_x1), 0);
                check("tmo_ce_x2", 32'(ce_x2), 0);
                check("tmo_bypass", 32'(bypass), 0);
            end
            tick();
        end
        check("tmo_scanlines", 32'(scanlines_out), 0);

        // Short lines lock into bypass and suppress scanlines.
        plain_lines(17, 600);
        check("byp_not_yet", 32'(locked), 0);
        drive_line(600, -1, 1'b0);
        check("byp_locked",    32'(locked),        1);
        check("byp_bypass",    32'(bypass),        1);
        check("byp_hs_period", 32'(hs_period),     600);
        check("byp_scanlines", 32'(scanlines_out), 0);

        // Jump by 6 cycles: unlock one line later, relock after 16 lines.
        drive_line(606, -1, 1'b0);
        check("jump_still", 32'(locked), 1);
        drive_line(606, -1, 1'b0);
        check("jump_unlock", 32'(locked), 0);
        check("jump_bypass", 32'(bypass), 0);
        plain_lines(15, 606);
        check("relock_not_yet", 32'(locked), 0);
        drive_line(606, -1, 1'b0);
        check("relock",           32'(locked),    1);
        check("relock_bypass",    32'(bypass),    1);
        check("relock_hs_period", 32'(hs_period), 606);

        // Asynchronous reset mid-line, sampled before any clock edge.
        for (int c = 0; c < 50; c++) tick();
        reset_n = 1'b0;
        #2;
        check("async_locked",    32'(locked),        0);
        check("async_bypass",    32'(bypass),        0);
        check("async_hs_period", 32'(hs_period),     0);
        check("async_scanlines", 32'(scanlines_out), 0);
        check("async_ce_x1",     32'(ce_x1),         0);
        check("async_ce_x2",     32'(ce_x2),         0);
        #2 reset_n = 1'b1;
        tick();

        // Alternating 300/305: off by one beyond tolerance, never locks.
        for (int i = 0; i < 20; i++) begin
            drive_line((i % 2 == 0) ? 300 : 305, -1, 1'b0);
            check("alt_nolock", 32'(locked), 0);
        end
        check("alt_hs_period", 32'(hs_period), 300);

        // Frame counting, including vsync coinciding with hsync.
        drive_line(32, 10, 1'b0);
        plain_lines(261, 32);
        drive_line(32, 10, 1'b0);
        check("frame_lines", 32'(vs_lines), 262);
        plain_lines(4, 32);
        drive_line(32, 0, 1'b0);
        check("frame_coincident", 32'(vs_lines), 4);
        plain_lines(3, 32);
        drive_line(32, 10, 1'b0);
        check("frame_after_coincident", 32'(vs_lines), 5);
        check("frame_field", 32'(field), 0);

        // Field detection on 2048-cycle lines.
        plain_lines(2, 2048);
        check("fld_hs_period", 32'(hs_period), 2048);
        drive_line(2048, 1025, 1'b0);
`ifdef SCANDOUBLER_CTRL_INTERLACE_EN
        check("fld_mid_line", 32'(field), 1);
`else
        check("fld_mid_line", 32'(field), 0);
`endif
        drive_line(2048, 1, 1'b0);
        check("fld_line_start", 32'(field), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
